l_operation: RTL and testbench

RC5 key-expansion front end: converts the secret key byte array K[0..B-1] into the word array L[0..C-1] by packing bytes little-endian into W-bit words. It reads key bytes from a key RAM and performs read-modify-write cycles on an L RAM (both instances of the shared dual-port RAM), then raises `done`. It runs once after reset and feeds the later S-table mixing stage.

---
 rtl/l_operation_pkg.sv | 16 +
 rtl/l_operation.sv | 81 ++++++++
 tb/tb_l_operation.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/l_operation_pkg.sv
// Shared definitions for the RC5 key-expansion L-array front end.
package l_operation_pkg;

  localparam int unsigned DefW   = 32;
  localparam int unsigned DefC   = 4;
  localparam int unsigned DefU   = DefW / 8;
  localparam int unsigned DefB   = DefC * DefU;
  localparam int unsigned RotAmt = 8;

  typedef enum logic [1:0] {
    StRead,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/l_operation.sv
// RC5 key-expansion front end: packs key bytes little-endian into the L word array through
// read-modify-write cycles on an external L RAM. Optional macro: L_OPERATION_ZERO_INIT_EN.
module l_operation
  import l_operation_pkg::*;
#(
  parameter int unsigned W = DefW,
  parameter int unsigned C = DefC,
  localparam int unsigned U        = W / 8,
  localparam int unsigned B        = C * U,
  localparam int unsigned C_length = $clog2(C),
  localparam int unsigned B_length = $clog2(B)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        L_sub_i,
  output logic [W-1:0]        L_sub_i_prima,
  output logic                L_we,
  output logic [C_length-1:0] L_address,
  output logic [B_length-1:0] key_address,
  input  logic [7:0]          key_sub_i,
  output logic                done
);

  localparam int unsigned U_length = $clog2(U);

  state_e              state_q, state_d;
  logic [B_length-1:0] idx_q, idx_d;
  logic [W-1:0]        l_old;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRead;
      idx_q   <= B_length'(B - 1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    L_we    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StRead: begin
        state_d = StWrite;
      end
      StWrite: begin
        L_we = 1'b1;
        if (idx_q == '0) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q - B_length'(1);
          state_d = StRead;
        end
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
        state_d = StRead;
      end
    endcase
  end

  assign key_address = idx_q;
  assign L_address   = C_length'(idx_q >> U_length);

`ifdef L_OPERATION_ZERO_INIT_EN
  // The most significant byte of each word is merged first; treat the stored word as zero then.
  logic first_byte;
  assign first_byte = (idx_q[U_length-1:0] == U_length'(U - 1));
  assign l_old      = first_byte ? '0 : L_sub_i;
`else
  assign l_old = L_sub_i;
`endif

  assign L_sub_i_prima = {l_old[W-RotAmt-1:0], l_old[W-1:W-RotAmt]} + W'(key_sub_i);

endmodule

// File: tb/tb_l_operation.sv
// Self-checking bench for l_operation: behavioural RAMs plus a byte-merge reference model.
module tb_l_operation;
  import l_operation_pkg::*;

  localparam int unsigned W  = DefW;
  localparam int unsigned C  = DefC;
  localparam int unsigned U  = DefU;
  localparam int unsigned B  = DefB;
  localparam int unsigned CL = $clog2(C);
  localparam int unsigned BL = $clog2(B);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  L_sub_i;
  logic [W-1:0]  L_sub_i_prima;
  logic          L_we;
  logic [CL-1:0] L_address;
  logic [BL-1:0] key_address;
  logic [7:0]    key_sub_i;
  logic          done;

  always #5 clk = ~clk;

  l_operation #(.W(W), .C(C)) dut (
    .clk           (clk),
    .rst           (rst),
    .L_sub_i       (L_sub_i),
    .L_sub_i_prima (L_sub_i_prima),
    .L_we          (L_we),
    .L_address     (L_address),
    .key_address   (key_address),
    .key_sub_i     (key_sub_i),
    .done          (done)
  );

  // Behavioural RAMs: registered read, write-first on the port used by the DUT.
  logic [7:0]   key_mem  [B];
  logic [W-1:0] l_mem    [C];
  logic [W-1:0] pre_vals [C];
  logic         load = 1'b0;
  logic [7:0]   key_q;
  logic [W-1:0] l_q;

  always @(posedge clk) begin
    key_q <= key_mem[key_address];
    if (load) begin
      for (int j = 0; j < C; j++) l_mem[j] <= pre_vals[j];
    end else if (L_we) begin
      l_mem[L_address] <= L_sub_i_prima;
    end
    l_q <= L_we ? L_sub_i_prima : l_mem[L_address];
  end

  assign key_sub_i = key_q;
  assign L_sub_i   = l_q;

  logic [BL+CL-1:0] wq[$];
  always @(negedge clk) begin
    if (L_we) wq.push_back({key_address, L_address});
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: L[i/U] = rotl8(L[i/U]) + K[i] for i from B-1 downwards.
  logic [W-1:0] m_l [C];
  logic [7:0]   m_k [B];

  function automatic logic [W-1:0] rotl8(input logic [W-1:0] x);
    return (x << 8) | (x >> (W - 8));
  endfunction

  task automatic model_merge(input int count);
    for (int n = 0; n < count; n++) begin
      int i;
      logic [W-1:0] base;
      i    = B - 1 - n;
      base = m_l[i / U];
`ifdef L_OPERATION_ZERO_INIT_EN
      if (i % U == U - 1) base = '0;
`endif
      m_l[i / U] = rotl8(base) + W'(m_k[i]);
    end
  endtask

  task automatic start_case(input logic [B*8-1:0] key, input logic [C*W-1:0] pre);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < B; i++) begin
      key_mem[i] = key[8*i +: 8];
      m_k[i]     = key[8*i +: 8];
    end
    for (int j = 0; j < C; j++) begin
      pre_vals[j] = pre[W*j +: W];
      m_l[j]      = pre[W*j +: W];
    end
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_eq("rst_key_addr", key_address, B - 1);
    check_eq("rst_l_addr", L_address, C - 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_we", L_we, 0);
    wq.delete();
    rst = 1'b0;
  endtask

  task automatic run_to_done();
    for (int k = 1; k <= 2 * B; k++) begin
      @(negedge clk);
      if (k == 2 * B - 1) check_eq("done_early", done, 0);
      if (k == 2 * B) check_eq("done_rise", done, 1);
    end
    model_merge(B);
    check_eq("we_count", wq.size(), B);
    for (int n = 0; n < B && n < wq.size(); n++) begin
      int unsigned ka;
      ka = B - 1 - n;
      check_eq("wr_addr", wq[n], {BL'(ka), CL'(ka / U)});
    end
    for (int j = 0; j < C; j++) check_eq("l_word", l_mem[j], m_l[j]);
  endtask

  initial begin
    logic [B*8-1:0] key;
    logic [C*W-1:0] pre;
    logic [W-1:0]   ref_l [C];
    int             we_seen;
    int             done_low;

    ref_l[0] = 32'h53000434;
    ref_l[1] = 32'h5FFE4938;
    ref_l[2] = 32'h8684FFF0;
    ref_l[3] = 32'hFFFEEEE5;

    // Reference key, L pre-cleared.
    key = 128'hFFFEEEE58684FFF05FFE493853000434;
    start_case(key, '0);
    run_to_done();
    for (int j = 0; j < C; j++) check_eq("ref_l", l_mem[j], ref_l[j]);

    // Idle after done.
    we_seen  = 0;
    done_low = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (L_we) we_seen++;
      if (!done) done_low++;
    end
    check_eq("idle_we", we_seen, 0);
    check_eq("idle_done_low", done_low, 0);
    for (int j = 0; j < C; j++) check_eq("idle_l", l_mem[j], ref_l[j]);

    // Preloaded L words: the stale contents feed the merge unless zero-init is built in.
    pre = {C{32'h01000000}};
    start_case(key, pre);
    run_to_done();

    // Reset after 10 cycles for 2 cycles; five bytes were already written.
    key = {$urandom, $urandom, $urandom, $urandom};
    start_case(key, '0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_key_addr", key_address, B - 1);
    check_eq("mid_l_addr", L_address, C - 1);
    check_eq("mid_done", done, 0);
    @(negedge clk);
    wq.delete();
    rst = 1'b0;
    model_merge(5);
    run_to_done();

    // Random keys and random preloads.
    for (int t = 0; t < 6; t++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pre = (t % 2 == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
      start_case(key, pre);
      run_to_done();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
